weight_glb_reader: RTL and testbench
====================================

# weight_glb_reader

Streams one compressed weight block out of a GLB weight bank toward the weight router GLB-side input (`GLB_address_in*`, `GLB_data_in*`). It has two independent channels:
- the 8-bit CSC address vector, read from the address SRAM;
- the 13-bit data vector (weight + count), read from the data SRAM.

Each channel hides the 1-cycle SRAM read latency behind a 2-entry output buffer and sustains 1 word/cycle under valid/ready backpressure. The GLB controller starts a transfer and waits for `done`.

## Interface
- `ADDR_AW`, 7: address-SRAM index width.
- `DATA_AW`, 9: data-SRAM index width.
- `clk` in 1: single clock; all logic rising-edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: transfer request; accepted only in IDLE.
- `addr_base` in ADDR_AW: first address-SRAM index, sampled on accept.
- `addr_len` in ADDR_AW+1: address words to send; 0 allowed.
- `data_base` in DATA_AW: first data-SRAM index, sampled on accept.
- `data_len` in DATA_AW+1: data words to send; 0 allowed.
- `busy` out 1: high in STREAM and DONE.
- `done` out 1: one-cycle pulse, transfer complete.
- `asram_rd_en` out 1, `asram_rd_idx` out ADDR_AW, `asram_rd_data` in 8: address SRAM; data valid the cycle after `rd_en`.
- `dsram_rd_en` out 1, `dsram_rd_idx` out DATA_AW, `dsram_rd_data` in 13: data SRAM; same 1-cycle latency.
- `out_address_valid` out 1, `out_address_ready` in 1, `out_address` out 8: to router `GLB_address_in`.
- `out_data_valid` out 1, `out_data_ready` in 1, `out_data` out 13: to router `GLB_data_in`.

## Operation
- FSM states: IDLE, STREAM, DONE.
  - IDLE → STREAM on `start`. Bases and lengths are latched, and the per-channel issue/delivered counters are cleared.
  - STREAM → DONE when both channels have delivered their full length.
  - DONE → IDLE unconditionally; `done` is high only in DONE.
- `start` outside IDLE is ignored; there is no queueing.
- Per channel:
  - Read issue condition: `issued < len` AND `buf_count + inflight − pop < 2`, where `pop` = valid & ready this cycle.
  - An issued read returns the next cycle and is written into the buffer.
  - Index = base + issued, wrapping modulo 2^AW.
- Output channel rules:
  - valid = `buf_count != 0`.
  - Data is the buffer head.
  - A word is consumed only on valid & ready.
  - Order is strictly SRAM index order.
- Channels are independent. One channel stalling never blocks the other. A channel with len 0 is complete on accept and never asserts `rd_en` or `valid`.
- Both lengths 0: STREAM lasts 1 cycle, then DONE.
- valid, once asserted, holds with stable data until ready (AXI-style). Valid never depends combinationally on ready.
- The buffer never overflows: the issue condition guarantees `buf_count + inflight ≤ 2`.
- Reset mid-transfer:
  - state returns to IDLE;
  - buffers are emptied;
  - in-flight SRAM returns in the following cycle are discarded;
  - no `done` is generated.
- Reset values: `busy` 0, `done` 0, both `rd_en` 0, both `valid` 0, `rd_idx` 0, `out_address` 0, `out_data` 0.

## Timing
- `start` sampled at edge T (IDLE):
  - STREAM from T+1;
  - first `rd_en` in cycle T+1;
  - SRAM data written at edge T+2 boundary (end of cycle T+2);
  - first `valid` in cycle T+3.
- With ready held high: one word per cycle after the first.
  - Channel of length N delivers its last word in cycle T+2+N.
  - `done` is in the cycle after the later channel's last handshake.
- Ready low for k cycles stalls issue within ≤1 cycle and adds exactly k cycles of delivery delay. No bubble after ready returns.
- Latency `start` → first valid: 3 cycles. Last handshake → `done`: 1 cycle. `done` → `start` accept possible: 1 cycle (IDLE).

## Structure
- Package `weight_glb_pkg`:
  - FSM state enum;
  - `WADDR_W`=8 and `WDATA_W`=13 (shared with the weight router / PE side);
  - `BUF_DEPTH`=2.
- Sub-module `glb_stream_channel`, parameterized by index width and word width, instantiated twice. It contains:
  - issue counter;
  - delivered counter;
  - inflight flag;
  - 2-entry buffer;
  - completion flag.
- Top holds the FSM, `start`/`done` logic and the base/len latches.

## Test plan
- **Basic stream:** addr_base 5, addr_len 4, data_base 100, data_len 6, both readies high → `out_address` = A[5..8], `out_data` = D[100..105] in order; first valid at T+3; `done` at T+9; no extra `rd_en`.
- **Backpressure:** `out_data_ready` toggling 1010…, address ready high → address finishes at T+6 unaffected; data order preserved; buffer never exceeds 2; `done` after the last data handshake.
- **Zero lengths:** addr_len 0, data_len 3 → `out_address_valid` never high, `asram_rd_en` never high, `done` at T+6. Both lengths 0 → `done` at T+2.
- **Wrap-around:** addr_base 126, addr_len 4 (ADDR_AW 7) → indices 126, 127, 0, 1.
- **Reset mid-transfer:** reset in cycle T+4 with data buffered → all outputs at reset values next cycle; no `done`. A new `start` then yields a clean full stream.
- **Start while busy:** second `start` pulse during STREAM → ignored; exactly one `done`.

Source files
------------

// File: rtl/weight_glb_reader_pkg.sv
// Shared types and sizes for the GLB weight-bank reader.
package weight_glb_pkg;

  // Word widths shared with the weight router / PE side.
  localparam int unsigned WADDR_W   = 8;
  localparam int unsigned WDATA_W   = 13;
  // Output buffer entries per channel; hides the 1-cycle SRAM latency.
  localparam int unsigned BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } glb_state_e;

endpackage

// File: rtl/weight_glb_reader_if.sv
// Valid/ready streams from the GLB reader to the weight router GLB-side input.
interface weight_glb_reader_if;
  import weight_glb_pkg::*;

  logic               out_address_valid;
  logic               out_address_ready;
  logic [WADDR_W-1:0] out_address;
  logic               out_data_valid;
  logic               out_data_ready;
  logic [WDATA_W-1:0] out_data;

  modport master (
    output out_address_valid, out_address, out_data_valid, out_data,
    input  out_address_ready, out_data_ready
  );

  modport slave (
    input  out_address_valid, out_address, out_data_valid, out_data,
    output out_address_ready, out_data_ready
  );

endinterface

// File: rtl/weight_glb_reader_channel.sv
// One SRAM-to-stream channel: issues reads ahead into a 2-entry buffer so a
// 1-cycle-latency SRAM can sustain one word per cycle under backpressure.
module glb_stream_channel
  import weight_glb_pkg::*;
#(
  parameter int unsigned IDX_W  = 7,
  parameter int unsigned WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active,
  input  logic              clear,
  input  logic [IDX_W-1:0]  base,
  input  logic [IDX_W:0]    len,
  output logic              rd_en_c,
  output logic [IDX_W-1:0]  rd_idx_c,
  input  logic [WORD_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic              complete_c
);

  localparam int unsigned CNT_W = IDX_W + 1;

  logic [CNT_W-1:0]  issued_q;
  logic [CNT_W-1:0]  delivered_q;
  logic [CNT_W-1:0]  delivered_n;
  logic              inflight_q;
  logic              complete_q;
  logic [1:0]        count_q;
  logic [1:0]        count_n;
  logic [WORD_W-1:0] tail_q;
  logic              pop_c;
  logic [2:0]        occ_c;

  // Issue decision, next occupancy and completion look-ahead.
  always_comb begin
    pop_c       = out_valid & out_ready;
    occ_c       = 3'(count_q) + 3'(inflight_q) - 3'(pop_c);
    rd_en_c     = active & (issued_q < len) & (occ_c < 3'(BUF_DEPTH));
    rd_idx_c    = base + issued_q[IDX_W-1:0];
    delivered_n = delivered_q + CNT_W'(pop_c);
    count_n     = count_q + 2'(inflight_q) - 2'(pop_c);
    complete_c  = complete_q | (delivered_n == len);
  end

  // Counters, in-flight tracking and the head/tail shift buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      issued_q    <= '0;
      delivered_q <= '0;
      complete_q  <= 1'b0;
      inflight_q  <= 1'b0;
      count_q     <= 2'd0;
      out_valid   <= 1'b0;
      out_word    <= '0;
      tail_q      <= '0;
    end else begin
      if (clear) begin
        issued_q    <= '0;
        delivered_q <= '0;
        complete_q  <= 1'b0;
      end else begin
        if (rd_en_c) issued_q <= issued_q + CNT_W'(1);
        delivered_q <= delivered_n;
        if (active && (delivered_n == len)) complete_q <= 1'b1;
      end
      inflight_q <= rd_en_c;
      count_q    <= count_n;
      out_valid  <= (count_n != 2'd0);
      case (count_q)
        2'd0: begin
          if (inflight_q) out_word <= rd_data;
        end
        2'd1: begin
          if (inflight_q && pop_c) out_word <= rd_data;
          else if (inflight_q)     tail_q   <= rd_data;
        end
        default: begin
          if (pop_c) out_word <= tail_q;
        end
      endcase
    end
  end

endmodule

// File: rtl/weight_glb_reader.sv
// Streams one compressed weight block (CSC address + data vectors) from the
// GLB weight bank to the weight router, then pulses done.
module weight_glb_reader
  import weight_glb_pkg::*;
#(
  parameter int unsigned ADDR_AW = 7,
  parameter int unsigned DATA_AW = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_AW-1:0] addr_base,
  input  logic [ADDR_AW:0]   addr_len,
  input  logic [DATA_AW-1:0] data_base,
  input  logic [DATA_AW:0]   data_len,
  output logic               busy,
  output logic               done,
  output logic               asram_rd_en,
  output logic [ADDR_AW-1:0] asram_rd_idx,
  input  logic [WADDR_W-1:0] asram_rd_data,
  output logic               dsram_rd_en,
  output logic [DATA_AW-1:0] dsram_rd_idx,
  input  logic [WDATA_W-1:0] dsram_rd_data,
  weight_glb_reader_if.master out_if
);

  glb_state_e         state_q;
  glb_state_e         state_n;
  logic               accept_c;
  logic               active_c;
  logic               addr_complete_c;
  logic               data_complete_c;
  logic [ADDR_AW-1:0] addr_base_q;
  logic [ADDR_AW:0]   addr_len_q;
  logic [DATA_AW-1:0] data_base_q;
  logic [DATA_AW:0]   data_len_q;

  // Next-state logic: accept in IDLE, finish when both channels delivered.
  always_comb begin
    state_n  = state_q;
    accept_c = 1'b0;
    active_c = (state_q == ST_STREAM);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_n  = ST_STREAM;
          accept_c = 1'b1;
        end
      end
      ST_STREAM: begin
        if (addr_complete_c && data_complete_c) state_n = ST_DONE;
      end
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // State register with registered busy/done decodes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      busy    <= (state_n != ST_IDLE);
      done    <= (state_n == ST_DONE);
    end
  end

  // Transfer parameters are captured once, on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_base_q <= '0;
      addr_len_q  <= '0;
      data_base_q <= '0;
      data_len_q  <= '0;
    end else if (accept_c) begin
      addr_base_q <= addr_base;
      addr_len_q  <= addr_len;
      data_base_q <= data_base;
      data_len_q  <= data_len;
    end
  end

  glb_stream_channel #(.IDX_W(ADDR_AW), .WORD_W(WADDR_W)) u_addr_chan (
    .clk        (clk),
    .reset      (reset),
    .active     (active_c),
    .clear      (accept_c),
    .base       (addr_base_q),
    .len        (addr_len_q),
    .rd_en_c    (asram_rd_en),
    .rd_idx_c   (asram_rd_idx),
    .rd_data    (asram_rd_data),
    .out_valid  (out_if.out_address_valid),
    .out_ready  (out_if.out_address_ready),
    .out_word   (out_if.out_address),
    .complete_c (addr_complete_c)
  );

  glb_stream_channel #(.IDX_W(DATA_AW), .WORD_W(WDATA_W)) u_data_chan (
    .clk        (clk),
    .reset      (reset),
    .active     (active_c),
    .clear      (accept_c),
    .base       (data_base_q),
    .len        (data_len_q),
    .rd_en_c    (dsram_rd_en),
    .rd_idx_c   (dsram_rd_idx),
    .rd_data    (dsram_rd_data),
    .out_valid  (out_if.out_data_valid),
    .out_ready  (out_if.out_data_ready),
    .out_word   (out_if.out_data),
    .complete_c (data_complete_c)
  );

endmodule

// File: tb/tb_weight_glb_reader.sv
// Randomized bench for weight_glb_reader with SRAM models and a queue-based
// reference of the expected word streams and transfer timing.
module tb_weight_glb_reader;

  localparam int unsigned AAW = 7;
  localparam int unsigned DAW = 9;
  localparam int ADEPTH = 128;
  localparam int DDEPTH = 512;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [AAW-1:0] addr_base;
  logic [AAW:0]   addr_len;
  logic [DAW-1:0] data_base;
  logic [DAW:0]   data_len;
  logic           busy;
  logic           done;
  logic           asram_rd_en;
  logic [AAW-1:0] asram_rd_idx;
  logic [7:0]     asram_rd_data = '0;
  logic           dsram_rd_en;
  logic [DAW-1:0] dsram_rd_idx;
  logic [12:0]    dsram_rd_data = '0;

  weight_glb_reader_if bus ();

  weight_glb_reader #(.ADDR_AW(AAW), .DATA_AW(DAW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .addr_base     (addr_base),
    .addr_len      (addr_len),
    .data_base     (data_base),
    .data_len      (data_len),
    .busy          (busy),
    .done          (done),
    .asram_rd_en   (asram_rd_en),
    .asram_rd_idx  (asram_rd_idx),
    .asram_rd_data (asram_rd_data),
    .dsram_rd_en   (dsram_rd_en),
    .dsram_rd_idx  (dsram_rd_idx),
    .dsram_rd_data (dsram_rd_data),
    .out_if        (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  amem [ADEPTH];
  logic [12:0] dmem [DDEPTH];
  logic [7:0]  q_addr [$];
  logic [12:0] q_data [$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int amode    = 0;
  int dmode    = 0;
  int a_base_m = 0, d_base_m = 0;
  int a_reads, d_reads, a_hs, d_hs, a_first, d_first, a_last, d_last;
  int a_vcyc, d_vcyc, done_cnt, done_cyc;
  logic a_pv = 1'b0, a_pr = 1'b0, d_pv = 1'b0, d_pr = 1'b0;
  logic [7:0]  a_pw = '0;
  logic [12:0] d_pw = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Registered-read SRAM models.
  always @(posedge clk) begin
    if (asram_rd_en) asram_rd_data <= amem[asram_rd_idx];
    if (dsram_rd_en) dsram_rd_data <= dmem[dsram_rd_idx];
    cyc <= cyc + 1;
  end

  function automatic logic rdy(input int mode);
    case (mode)
      0:       return 1'b1;
      1:       return ((cyc % 2) == 0);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Ready drivers per channel mode: 0 always, 1 toggling, 2 random.
  initial begin
    bus.out_address_ready = 1'b1;
    bus.out_data_ready    = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_address_ready = rdy(amode);
      bus.out_data_ready    = rdy(dmode);
    end
  end

  // Monitor: scoreboard, index order, occupancy bound, hold-until-ready.
  always @(negedge clk) begin
    if (reset) begin
      a_pv = 1'b0;
      d_pv = 1'b0;
    end else begin
      if (asram_rd_en) begin
        check_eq("addr_rd_idx", 32'(asram_rd_idx), 32'((a_base_m + a_reads) % ADEPTH));
        check_eq("addr_occupancy",
                 32'((a_reads + 1 - a_hs - ((bus.out_address_valid && bus.out_address_ready) ? 1 : 0)) <= 2), 1);
        a_reads++;
      end
      if (dsram_rd_en) begin
        check_eq("data_rd_idx", 32'(dsram_rd_idx), 32'((d_base_m + d_reads) % DDEPTH));
        check_eq("data_occupancy",
                 32'((d_reads + 1 - d_hs - ((bus.out_data_valid && bus.out_data_ready) ? 1 : 0)) <= 2), 1);
        d_reads++;
      end
      if (a_pv && !a_pr) begin
        check_eq("addr_hold_valid", 32'(bus.out_address_valid), 1);
        check_eq("addr_hold_word", 32'(bus.out_address), 32'(a_pw));
      end
      if (d_pv && !d_pr) begin
        check_eq("data_hold_valid", 32'(bus.out_data_valid), 1);
        check_eq("data_hold_word", 32'(bus.out_data), 32'(d_pw));
      end
      if (bus.out_address_valid) a_vcyc++;
      if (bus.out_data_valid) d_vcyc++;
      if (bus.out_address_valid && bus.out_address_ready) begin
        if (q_addr.size() > 0) check_eq("addr_word", 32'(bus.out_address), 32'(q_addr.pop_front()));
        if (a_hs == 0) a_first = cyc;
        a_hs++;
        a_last = cyc;
      end
      if (bus.out_data_valid && bus.out_data_ready) begin
        if (q_data.size() > 0) check_eq("data_word", 32'(bus.out_data), 32'(q_data.pop_front()));
        if (d_hs == 0) d_first = cyc;
        d_hs++;
        d_last = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      a_pv = bus.out_address_valid;
      a_pr = bus.out_address_ready;
      a_pw = bus.out_address;
      d_pv = bus.out_data_valid;
      d_pr = bus.out_data_ready;
      d_pw = bus.out_data;
    end
  end

  task automatic clear_counts();
    a_reads = 0; d_reads = 0; a_hs = 0; d_hs = 0;
    a_first = -1; d_first = -1; a_last = -1; d_last = -1;
    a_vcyc = 0; d_vcyc = 0; done_cnt = 0; done_cyc = -1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
    check_eq({tag, "_a_rd_en"}, 32'(asram_rd_en), 0);
    check_eq({tag, "_d_rd_en"}, 32'(dsram_rd_en), 0);
    check_eq({tag, "_a_rd_idx"}, 32'(asram_rd_idx), 0);
    check_eq({tag, "_d_rd_idx"}, 32'(dsram_rd_idx), 0);
    check_eq({tag, "_a_valid"}, 32'(bus.out_address_valid), 0);
    check_eq({tag, "_d_valid"}, 32'(bus.out_data_valid), 0);
    check_eq({tag, "_a_word"}, 32'(bus.out_address), 0);
    check_eq({tag, "_d_word"}, 32'(bus.out_data), 0);
  endtask

  // Builds the expected streams and drives the start pulse; returns T.
  task automatic launch(input int ab, input int al, input int db, input int dl, output int t0);
    q_addr.delete();
    q_data.delete();
    for (int i = 0; i < al; i++) q_addr.push_back(amem[AAW'((ab + i) % ADEPTH)]);
    for (int i = 0; i < dl; i++) q_data.push_back(dmem[DAW'((db + i) % DDEPTH)]);
    a_base_m = ab;
    d_base_m = db;
    clear_counts();
    @(posedge clk);
    #1;
    start     = 1'b1;
    addr_base = AAW'(ab);
    addr_len  = (AAW + 1)'(al);
    data_base = DAW'(db);
    data_len  = (DAW + 1)'(dl);
    t0        = cyc;
    @(posedge clk);
    #1;
    start     = 1'b0;
    addr_base = AAW'($urandom);
    addr_len  = (AAW + 1)'($urandom);
    data_base = DAW'($urandom);
    data_len  = (DAW + 1)'($urandom);
  endtask

  task automatic run(input int ab, input int al, input int db, input int dl,
                     input int am, input int dm, input int dup);
    int t0, tmo, last, exp_done;
    amode = am;
    dmode = dm;
    launch(ab, al, db, dl, t0);
    @(negedge clk);
    check_eq("busy_stream", 32'(busy), 1);
    if (dup != 0) begin
      @(posedge clk);
      #1;
      start     = 1'b1;
      addr_len  = 8'd3;
      data_len  = 10'd2;
      @(posedge clk);
      #1;
      start     = 1'b0;
    end
    tmo = 0;
    while (done_cnt == 0 && tmo < 1000) begin
      @(posedge clk);
      tmo++;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("done_count", 32'(done_cnt), 1);
    check_eq("busy_idle", 32'(busy), 0);
    check_eq("addr_hs_count", 32'(a_hs), 32'(al));
    check_eq("data_hs_count", 32'(d_hs), 32'(dl));
    check_eq("addr_rd_count", 32'(a_reads), 32'(al));
    check_eq("data_rd_count", 32'(d_reads), 32'(dl));
    last = (a_last > d_last) ? a_last : d_last;
    exp_done = (al == 0 && dl == 0) ? t0 + 2 : last + 1;
    check_eq("done_cycle", 32'(done_cyc), 32'(exp_done));
    if (am == 0 && al > 0) begin
      check_eq("addr_first_cycle", 32'(a_first), 32'(t0 + 3));
      check_eq("addr_last_cycle", 32'(a_last), 32'(t0 + 2 + al));
    end
    if (dm == 0 && dl > 0) begin
      check_eq("data_first_cycle", 32'(d_first), 32'(t0 + 3));
      check_eq("data_last_cycle", 32'(d_last), 32'(t0 + 2 + dl));
    end
    if (am == 0 && dm == 0)
      check_eq("done_abs_cycle", 32'(done_cyc),
               32'((al == 0 && dl == 0) ? t0 + 2 : t0 + 3 + ((al > dl) ? al : dl)));
    if (al == 0) check_eq("addr_valid_cycles", 32'(a_vcyc), 0);
    if (dl == 0) check_eq("data_valid_cycles", 32'(d_vcyc), 0);
  endtask

  // Reset in cycle T+4 with words buffered: clean outputs, no done, no leftovers.
  task automatic reset_test();
    int t0;
    amode = 0;
    dmode = 0;
    launch(5, 4, 100, 6, t0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_counts();
    @(negedge clk);
    check_reset_vals("mid_rst");
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_eq("rst_no_done", 32'(done_cnt), 0);
    check_eq("rst_no_addr_valid", 32'(a_vcyc), 0);
    check_eq("rst_no_data_valid", 32'(d_vcyc), 0);
    check_eq("rst_no_reads", 32'(a_reads + d_reads), 0);
  endtask

  initial begin
    for (int i = 0; i < ADEPTH; i++) amem[i] = 8'($urandom);
    for (int i = 0; i < DDEPTH; i++) dmem[i] = 13'($urandom);
    clear_counts();
    reset     = 1'b1;
    start     = 1'b0;
    addr_base = '0;
    addr_len  = '0;
    data_base = '0;
    data_len  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;

    run(5, 4, 100, 6, 0, 0, 0);     // basic stream
    run(5, 4, 100, 6, 0, 1, 0);     // data backpressure 1010
    run(0, 0, 20, 3, 0, 0, 0);      // address length 0
    run(3, 0, 7, 0, 0, 0, 0);       // both lengths 0
    run(126, 4, 510, 5, 0, 0, 0);   // index wrap-around
    run(10, 5, 30, 7, 0, 0, 1);     // start while busy
    reset_test();
    run(5, 4, 100, 6, 0, 0, 0);     // clean stream after reset
    for (int n = 0; n < 12; n++) begin
      int al, dl;
      al = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 14);
      dl = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 14);
      run($urandom_range(0, ADEPTH - 1), al, $urandom_range(0, DDEPTH - 1), dl,
          $urandom_range(0, 2), $urandom_range(0, 2), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
